bcd_decade_down_counter: RTL and testbench



---
 rtl/bcd_decade_down_counter.sv | 76 +++++++
 tb/tb_bcd_decade_down_counter.sv | 164 ++++++++++++++++
 2 files changed

// File: rtl/bcd_decade_down_counter.sv
// Purpose : cascadable multi-digit BCD down counter with clamped parallel load.
// Latency : q updates one clock edge after load/enable is sampled; zero/borrow are combinational from q and enable.
// Backpres: none; enable acts as borrow-in, and borrow drives the enable of the next stage.
//
// Ports:
//   clock       rising-edge clock for all state
//   reset_n     asynchronous active-low reset, clears q to 0
//   enable      count-down enable (borrow-in when cascading)
//   load        synchronous parallel load, priority over enable
//   load_value  BCD load value, digit i in bits [4i+3:4i]; digits 10..15 load as 9
//   q           current count, digit 0 least significant
//   zero        all digits of q are 0
//   borrow      enable & zero, borrow-out to the next counter's enable
//
// Build option: define BCD_DOWN_COUNTER_HOLD_AT_ZERO_EN to make the counter
// saturate at 0 instead of wrapping to all nines.

module bcd_decade_down_counter #(
  parameter int DIGITS = 2
) (
  input  logic                  clock,
  input  logic                  reset_n,
  input  logic                  enable,
  input  logic                  load,
  input  logic [4*DIGITS-1:0]   load_value,
  output logic [4*DIGITS-1:0]   q,
  output logic                  zero,
  output logic                  borrow
);

  logic [DIGITS-1:0][3:0] cnt_q;
  logic [DIGITS-1:0][3:0] cnt_d;
  logic                   all_zero;
  logic                   dec_run;
  logic [3:0]             ld_digit;

  assign all_zero = (cnt_q == '0);

  always_comb begin
    cnt_d    = cnt_q;
    dec_run  = enable;
    ld_digit = 4'd0;
    for (int i = 0; i < DIGITS; i++) begin
      if (load) begin
        ld_digit = load_value[4*i +: 4];
        cnt_d[i] = (ld_digit > 4'd9) ? 4'd9 : ld_digit;
      end else if (dec_run) begin
        // dec_run is high here only when enable is set and every lower digit is 0
        if (cnt_q[i] == 4'd0) begin
`ifdef BCD_DOWN_COUNTER_HOLD_AT_ZERO_EN
          // saturate when the whole count is 0; otherwise a normal digit borrow
          cnt_d[i] = all_zero ? 4'd0 : 4'd9;
`else
          cnt_d[i] = 4'd9;
`endif
        end else begin
          cnt_d[i] = cnt_q[i] - 4'd1;
        end
      end
      dec_run = dec_run & (cnt_q[i] == 4'd0);
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign q      = cnt_q;
  assign zero   = all_zero;
  assign borrow = enable & all_zero;

endmodule

// File: tb/tb_bcd_decade_down_counter.sv
module tb_bcd_decade_down_counter;

`ifdef BCD_DOWN_COUNTER_HOLD_AT_ZERO_EN
  localparam bit HOLD = 1'b1;
`else
  localparam bit HOLD = 1'b0;
`endif

  logic       clock = 1'b0;
  logic       reset_n = 1'b0;
  logic       enable = 1'b0;
  logic       load = 1'b0;
  logic [7:0] load_value = 8'h00;
  logic [7:0] q;
  logic       zero, borrow;
  logic [3:0] lo_q, hi_q;
  logic       lo_zero, lo_borrow, hi_zero, hi_borrow;

  int  checks = 0;
  int  errors = 0;
  int  model  = 0;   // decimal value the two-digit counter must hold
  bit  cmp_en = 1'b0;

  always #5 clock = ~clock;

  bcd_decade_down_counter #(.DIGITS(2)) dut (
    .clock(clock), .reset_n(reset_n), .enable(enable), .load(load),
    .load_value(load_value), .q(q), .zero(zero), .borrow(borrow)
  );

  bcd_decade_down_counter #(.DIGITS(1)) u_lo (
    .clock(clock), .reset_n(reset_n), .enable(enable), .load(load),
    .load_value(load_value[3:0]), .q(lo_q), .zero(lo_zero), .borrow(lo_borrow)
  );

  bcd_decade_down_counter #(.DIGITS(1)) u_hi (
    .clock(clock), .reset_n(reset_n), .enable(lo_borrow), .load(load),
    .load_value(load_value[7:4]), .q(hi_q), .zero(hi_zero), .borrow(hi_borrow)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual %0h required %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [7:0] to_bcd(input int v);
    return {4'(v / 10 % 10), 4'(v % 10)};
  endfunction

  function automatic int clamp_val(input logic [7:0] lv);
    int hi, lo;
    hi = (lv[7:4] > 4'd9) ? 9 : int'(lv[7:4]);
    lo = (lv[3:0] > 4'd9) ? 9 : int'(lv[3:0]);
    return hi * 10 + lo;
  endfunction

  // One clock of stimulus; the model follows the decimal rules of the counter.
  task automatic step(input logic ld, input logic en, input logic [7:0] lv);
    @(negedge clock);
    #1;
    load = ld; enable = en; load_value = lv;
    @(posedge clock);
    if (ld)            model = clamp_val(lv);
    else if (en) begin
      if (model == 0)  model = HOLD ? 0 : 99;
      else             model = model - 1;
    end
    #1;
  endtask

  always @(negedge clock) begin
    if (cmp_en && reset_n) begin
      check("q_model", 32'(q), 32'(to_bcd(model)));
      check("zero_model", 32'(zero), 32'(model == 0));
      check("borrow_model", 32'(borrow), 32'(enable && (model == 0)));
`ifndef BCD_DOWN_COUNTER_HOLD_AT_ZERO_EN
      check("cascade_model", 32'({hi_q, lo_q}), 32'(to_bcd(model)));
`endif
    end
  end

  initial begin
    #2;
    check("reset_q", 32'(q), 32'h00);
    check("reset_zero", 32'(zero), 32'd1);
    check("reset_borrow", 32'(borrow), 32'd0);
    #10;
    reset_n = 1'b1;
    cmp_en  = 1'b1;

    // asynchronous reset mid-cycle, then a load held while in reset is discarded
    step(1'b1, 1'b0, 8'h47);
    check("load_47", 32'(q), 32'h47);
    #3;
    reset_n = 1'b0;
    model   = 0;
    #1;
    check("async_rst_q", 32'(q), 32'h00);
    check("async_rst_zero", 32'(zero), 32'd1);
    load = 1'b1; load_value = 8'h88;
    @(posedge clock);
    #1;
    check("rst_discards_load", 32'(q), 32'h00);
    @(negedge clock);
    #2;
    load = 1'b0;
    reset_n = 1'b1;

    // load and count through the wrap
    step(1'b1, 1'b0, 8'h23);
    check("load_23", 32'(q), 32'h23);
    for (int k = 0; k < 24; k++) begin
      step(1'b0, 1'b1, 8'h00);
      if (k == 2)  check("count_20", 32'(q), 32'h20);
      if (k == 3)  check("count_19", 32'(q), 32'h19);
      if (k == 22) check("count_00", 32'(q), 32'h00);
      if (k == 22) check("borrow_at_00", 32'(borrow), 32'd1);
    end
    check("wrap_99", 32'(q), HOLD ? 32'h00 : 32'h99);

    // per-digit clamp on load
    step(1'b1, 1'b0, 8'hA5);
    check("clamp_A5", 32'(q), 32'h95);
    step(1'b1, 1'b0, 8'h3F);
    check("clamp_3F", 32'(q), 32'h39);

    // load wins over enable, then hold
    step(1'b1, 1'b1, 8'h50);
    check("load_priority", 32'(q), 32'h50);
    for (int k = 0; k < 5; k++) step(1'b0, 1'b0, 8'h00);
    check("hold_50", 32'(q), 32'h50);

    // cascade from 0
    step(1'b1, 1'b0, 8'h00);
`ifndef BCD_DOWN_COUNTER_HOLD_AT_ZERO_EN
    step(1'b0, 1'b1, 8'h00);
    check("cascade_hi_9", 32'(hi_q), 32'h9);
    check("cascade_lo_9", 32'(lo_q), 32'h9);
    check("dut_99", 32'(q), 32'h99);
`endif
    for (int k = 0; k < 200; k++) begin
      step(($urandom_range(0, 19) == 0), ($urandom_range(0, 3) != 0), 8'($urandom));
    end

`ifdef BCD_DOWN_COUNTER_HOLD_AT_ZERO_EN
    step(1'b1, 1'b0, 8'h02);
    check("hold_load_02", 32'(q), 32'h02);
    for (int k = 0; k < 5; k++) begin
      step(1'b0, 1'b1, 8'h00);
      check("hold_q", 32'(q), (k == 0) ? 32'h01 : 32'h00);
      check("hold_borrow", 32'(borrow), (k == 0) ? 32'd0 : 32'd1);
    end
`endif

    @(negedge clock);
    #1;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
